// File: rtl/cmd_sequencer.sv
// Command sequencer: streams a byte range from a ROM to a UART, then waits for a
// terminator byte, retransmitting the whole command on response timeout.
module cmd_sequencer #(
  parameter int          ADDR_W      = 5,
  parameter int          LEN_W       = 4,
  parameter logic [7:0]  RESP_BYTE   = 8'h0A,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              busy,
  output logic              resp_rcvd,
  output logic              timeout_err,
  output logic [3:0]        retry_cnt
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    XMIT,
    TX_WAIT,
    RESP_WAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] start_lat;
  logic [LEN_W-1:0]  len_lat;
  logic [LEN_W-1:0]  remaining;
  logic [TMR_W-1:0]  timer;
  logic              resp_match;

  // The match must be seen in the same cycle the byte arrives, so it is decoded here.
  assign resp_match = (state == RESP_WAIT) && rx_rdy && (rx_data == RESP_BYTE);
  assign resp_rcvd  = resp_match;
  assign clr_rx_rdy = rx_rdy;
  assign tx_data    = rom_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= '0;
      start_lat   <= '0;
      len_lat     <= '0;
      remaining   <= '0;
      timer       <= '0;
      trmt        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: begin
          if (send && (cmd_len != '0)) begin
            start_lat   <= cmd_start;
            len_lat     <= cmd_len;
            rom_addr    <= cmd_start;
            remaining   <= cmd_len;
            retry_cnt   <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          trmt  <= 1'b1;
          state <= XMIT;
        end
        XMIT: begin
          rom_addr  <= rom_addr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          state     <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            if (remaining != '0) begin
              state <= FETCH;
            end else begin
              timer <= '0;
              state <= RESP_WAIT;
            end
          end
        end
        RESP_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (resp_match) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TMR_LAST) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 4'd1;
              rom_addr  <= start_lat;
              remaining <= len_lat;
              state     <= FETCH;
            end else begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized bench for cmd_sequencer: ROM and UART models plus a cycle-level
// expectation tracker derived from the command/response rules.
module tb_cmd_sequencer;
  localparam int         T    = 64;
  localparam int         MAXR = 2;
  localparam logic [7:0] RESP = 8'h0A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [4:0] cmd_start = '0;
  logic [3:0] cmd_len = '0;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       clr_rx_rdy;
  logic       busy;
  logic       resp_rcvd;
  logic       timeout_err;
  logic [3:0] retry_cnt;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         tx_delay = 5;
  int         tx_cnt = 0;
  bit         noise_en = 1'b0;
  logic       last_err = 1'b0;
  logic [7:0] rom [32];

  cmd_sequencer #(
    .ADDR_W(5), .LEN_W(4), .RESP_BYTE(RESP), .TIMEOUT_CYC(T), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .busy(busy), .resp_rcvd(resp_rcvd), .timeout_err(timeout_err), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // UART transmitter: tx_done drops on trmt and returns tx_delay cycles later.
  always @(posedge clk) begin
    if (trmt) begin
      tx_done <= 1'b0;
      tx_cnt  <= tx_delay;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at 1 time unit after a rising edge with the DUT idle.
  // r0..r2: response delay (cycles after the last tx_done) per attempt, 0 = silent.
  task automatic run_cmd(input logic [4:0] start, input logic [3:0] len, input int txd,
                         input int r0, input int r1, input int r2,
                         input bit junk, input bit poke);
    int plan [3];
    int s, k, attempt, nbytes, total, exp_trmt, rx_at, win_end, kind;
    bit wait_done, in_win, poked;
    logic [4:0] addr;
    plan = '{r0, r1, r2};
    tx_delay = txd;
    send = 1'b1; cmd_start = start; cmd_len = len;
    s = cyc;
    @(posedge clk); #1;
    attempt = 0; nbytes = 0; total = 0; exp_trmt = s + 2; rx_at = -1; win_end = -1;
    kind = 0; k = 0; wait_done = 0; in_win = 0; poked = 0;
    while (kind == 0 && k < 4000) begin
      send = 1'b0;
      cmd_start = 5'($urandom);
      cmd_len = 4'($urandom);
      rx_rdy = 1'b0;
      rx_data = 8'($urandom);
      if (in_win) begin
        if (cyc == rx_at) begin
          rx_rdy = 1'b1; rx_data = RESP;
        end else if (junk && rx_at >= 0 && cyc == rx_at - 1) begin
          rx_rdy = 1'b1; rx_data = 8'h55;
        end
      end else if (noise_en && $urandom_range(0, 3) == 0) begin
        rx_rdy = 1'b1;
        rx_data = ($urandom_range(0, 1) == 1) ? RESP : 8'($urandom);
      end
      #1;
      check("clr_rx_rdy", clr_rx_rdy, rx_rdy);
      check("resp_rcvd", resp_rcvd, in_win && cyc == rx_at);
      check("busy", busy, 1'b1);
      check("trmt", trmt, cyc == exp_trmt);
      check("retry_cnt", retry_cnt, attempt);
      check("timeout_err", timeout_err, 1'b0);
      if (trmt) begin
        addr = start + 5'(nbytes);
        check("tx_data", tx_data, rom[addr]);
        nbytes++; total++;
        wait_done = 1; exp_trmt = -1;
      end else if (wait_done) begin
        if (tx_done) begin
          wait_done = 0;
          if (nbytes < int'(len)) begin
            exp_trmt = cyc + 2;
          end else begin
            in_win = 1;
            win_end = cyc + T;
            rx_at = (plan[attempt] > 0) ? cyc + plan[attempt] : -1;
          end
        end else if (poke && !poked) begin
          send = 1'b1; cmd_start = 5'($urandom); cmd_len = 4'($urandom_range(1, 15));
          poked = 1;
        end
      end
      if (in_win && cyc == rx_at) begin
        kind = 1;
      end else if (in_win && cyc == win_end) begin
        if (attempt < MAXR) begin
          attempt++; nbytes = 0; in_win = 0; rx_at = -1; exp_trmt = cyc + 2;
        end else begin
          kind = 2;
        end
      end
      k++;
      @(posedge clk); #1;
    end
    if (kind == 0) check("cycle_budget", 1'b0, 1'b1);
    send = 1'b0; rx_rdy = 1'b0;
    #1;
    check("end_busy", busy, 1'b0);
    check("end_trmt", trmt, 1'b0);
    check("end_resp", resp_rcvd, 1'b0);
    check("end_timeout_err", timeout_err, kind == 2);
    check("end_retry_cnt", retry_cnt, attempt);
    check("trmt_total", total, int'(len) * (attempt + 1));
    last_err = (kind == 2);
    $display("cmd start=%0d len=%0d txd=%0d attempts=%0d outcome=%s", start, len, txd,
             attempt + 1, (kind == 1) ? "response" : "timeout");
  endtask

  task automatic zero_len_send();
    send = 1'b1; cmd_start = 5'($urandom); cmd_len = 4'd0;
    @(posedge clk); #1;
    send = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("zl_busy", busy, 1'b0);
      check("zl_trmt", trmt, 1'b0);
      check("zl_timeout_err", timeout_err, last_err);
      @(posedge clk); #1;
    end
    $display("cmd len=0 ignored");
  endtask

  task automatic reset_mid_cmd();
    int n, k;
    tx_delay = 10;
    send = 1'b1; cmd_start = 5'd10; cmd_len = 4'd5;
    @(posedge clk); #1;
    send = 1'b0; n = 0; k = 0;
    while (n < 2 && k < 200) begin
      if (trmt) n++;
      @(posedge clk); #1;
      k++;
    end
    check("rst_two_bytes", n, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_trmt", trmt, 1'b0);
    check("rst_retry_cnt", retry_cnt, 4'd0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_rom_addr", rom_addr, 5'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (trmt || busy) n++;
    end
    check("rst_quiet", n, 0);
    last_err = 1'b0;
    $display("cmd start=10 len=5 aborted by reset");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'(i * 37 + 11);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_trmt", trmt, 1'b0);
    check("reset_resp", resp_rcvd, 1'b0);
    check("reset_timeout_err", timeout_err, 1'b0);
    check("reset_retry_cnt", retry_cnt, 4'd0);
    check("reset_rom_addr", rom_addr, 5'd0);
    rst_n = 1'b1;

    run_cmd(5'd3, 4'd4, 10, 5, 0, 0, 1'b0, 1'b0);
    run_cmd(5'd30, 4'd4, 3, 7, 0, 0, 1'b0, 1'b0);
    run_cmd(5'd8, 4'd2, 4, 10, 0, 0, 1'b1, 1'b0);
    run_cmd(5'd0, 4'd2, 5, 0, 0, 0, 1'b0, 1'b0);
    zero_len_send();
    run_cmd(5'd12, 4'd3, 8, 20, 0, 0, 1'b0, 1'b1);
    run_cmd(5'd5, 4'd3, 2, 0, T, 0, 1'b0, 1'b0);
    run_cmd(5'd17, 4'd1, 1, T, 0, 0, 1'b0, 1'b0);
    reset_mid_cmd();

    noise_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int p [3];
      for (int a = 0; a < 3; a++) begin
        int r;
        r = $urandom_range(0, 9);
        p[a] = (r < 3) ? 0 : (r == 3) ? T : $urandom_range(1, T);
      end
      run_cmd(5'($urandom), 4'($urandom_range(1, 15)), $urandom_range(1, 12),
              p[0], p[1], p[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) zero_len_send();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
